yuv2rgb_pipe: RTL and testbench
===============================

YUV2RGB_PIPE -- requirements
Module: yuv2rgb_pipe

Interface
REQ-001 Parameter DATA_W, default 8: component width, legal 8..12.
REQ-002 Parameter FRAC, default 8: coefficient fractional bits, legal 6..10.
REQ-003 Parameter SATC_W, default 16: saturation-counter width.
REQ-004 clk  in  1  sole clock, rising edge.
REQ-005 rst  in  1  reset, asynchronous, active-high.
REQ-006 in_valid  in  1  input beat valid.
REQ-007 in_ready  out  1  block accepts a beat this cycle.
REQ-008 in_y, in_u, in_v  in  DATA_W each  unsigned Y, Cb, Cr.
REQ-009 in_mode  in  1  0 = BT.601, 1 = BT.709; sampled with each beat.
REQ-010 in_sof, in_eol  in  1 each  sideband flags, carried with the pixel.
REQ-011 out_valid  out  1  output beat valid.
REQ-012 out_ready  in  1  downstream accepts the beat.
REQ-013 out_r, out_g, out_b  out  DATA_W each  clamped RGB.
REQ-014 out_sof, out_eol  out  1 each  sideband delayed with the pixel.
REQ-015 sat_cnt  out  SATC_W  count of clipped components since reset or clear.
REQ-016 sat_clr  in  1  synchronous clear of sat_cnt.

Function
REQ-017 Fixed 3-stage pipeline; S1 registers inputs and diffs, S2 registers products, S3 registers sum/round/clamp.
REQ-018 Global advance enable en = !out_valid || out_ready; in_ready = en, combinational.
REQ-019 Beat accepted when in_valid && in_ready; a stage valid bit moves forward only when en=1.
REQ-020 Latency 3 clk from acceptance to out_valid with no stall; throughput 1 pixel/clk when out_ready=1.
REQ-021 While out_valid && !out_ready, all output and pipeline registers hold; no beat lost, duplicated or reordered.
REQ-022 Bubbles (in_valid=0 while en=1) propagate as invalid stages.
REQ-023 OFF = 2^(DATA_W-1); Ud = in_u - OFF, Vd = in_v - OFF, signed DATA_W+1 bits.
REQ-024 Coefficients signed 12-bit, per mode (FRAC=8 values; other FRAC = round(real * 2^FRAC)).
REQ-025 BT.601: KR_V=359, KG_U=-88, KG_V=-183, KB_U=454.
REQ-026 BT.709: KR_V=403, KG_U=-48, KG_V=-120, KB_U=475.
REQ-027 Sums: R = (Y<<FRAC) + KR_V*Vd + H; G = (Y<<FRAC) + KG_U*Ud + KG_V*Vd + H; B = (Y<<FRAC) + KB_U*Ud + H; H = 2^(FRAC-1).
REQ-028 Sums are signed, at least DATA_W+FRAC+5 bits, no intermediate overflow.
REQ-029 Result = sum >>> FRAC (arithmetic, floor after +H).
REQ-030 Clamp: result < 0 -> 0; result > 2^DATA_W-1 -> 2^DATA_W-1.
REQ-031 sat_cnt += number of components clipped (0..3) when the S3 beat advances valid.
REQ-032 sat_cnt saturates at all-ones, never wraps.
REQ-033 sat_clr=1 sets sat_cnt to 0 that cycle and takes priority over a simultaneous increment.
REQ-034 in_mode, in_sof and in_eol travel in lockstep with their pixel; a mode change between consecutive beats takes effect per pixel.

Reset
REQ-035 rst=1 asynchronously clears all stage valid bits, out_valid, out_r/g/b, out_sof, out_eol and sat_cnt to 0.
REQ-036 Data in flight during reset is discarded; the first beat after deassertion appears 3 clk after acceptance.
REQ-037 in_ready is 1 during and after reset (out_valid=0).

Verification (DATA_W=8, FRAC=8)
REQ-038 BT.601, Y/U/V = 128/128/128 -> after 3 clk RGB = 128/128/128, sat_cnt 0; repeat in BT.709, same result.
REQ-039 BT.601, 255/128/255 -> RGB = 255/164/255, sat_cnt +1 (R clipped).
REQ-040 BT.601, 0/0/0 -> RGB = 0/136/0, sat_cnt +2.
REQ-041 Stream 5 beats and hold out_ready=0 from the cycle the first output is valid:
- out_valid and outputs stay stable;
- in_ready=0;
- after release, all 5 beats emerge in order with sof/eol intact.
REQ-042 Assert rst for 1 clk with 2 beats in flight -> out_valid=0 immediately, no stale beat appears, sat_cnt=0.
REQ-043 sat_clr coincident with a clipping beat -> sat_cnt=0 next cycle; force 2^16 clips -> sat_cnt holds 0xFFFF.

Source files
------------

// File: rtl/yuv2rgb_pipe.sv
// yuv2rgb_pipe: three-stage YCbCr -> RGB converter with BT.601/BT.709
// selection per pixel, global-stall valid/ready flow control, output
// clamping and a saturating counter of clipped components.
module yuv2rgb_pipe #(
    parameter int DATA_W = 8,
    parameter int FRAC   = 8,
    parameter int SATC_W = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_y,
    input  logic [DATA_W-1:0] in_u,
    input  logic [DATA_W-1:0] in_v,
    input  logic              in_mode,
    input  logic              in_sof,
    input  logic              in_eol,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_r,
    output logic [DATA_W-1:0] out_g,
    output logic [DATA_W-1:0] out_b,
    output logic              out_sof,
    output logic              out_eol,
    output logic [SATC_W-1:0] sat_cnt,
    input  logic              sat_clr
);

    localparam int DIFF_W = DATA_W + 1;
    localparam int PROD_W = DATA_W + 13;
    localparam int SUM_W  = DATA_W + FRAC + 5;
    localparam real SCALE = 2.0 ** FRAC;

    // Coefficients rounded from the real matrix values at elaboration time.
    localparam logic signed [11:0] KR_V_601 = 12'(int'(1.402 * SCALE));
    localparam logic signed [11:0] KG_U_601 = 12'(int'(-0.344136 * SCALE));
    localparam logic signed [11:0] KG_V_601 = 12'(int'(-0.714136 * SCALE));
    localparam logic signed [11:0] KB_U_601 = 12'(int'(1.772 * SCALE));
    localparam logic signed [11:0] KR_V_709 = 12'(int'(1.5748 * SCALE));
    localparam logic signed [11:0] KG_U_709 = 12'(int'(-0.187324 * SCALE));
    localparam logic signed [11:0] KG_V_709 = 12'(int'(-0.468124 * SCALE));
    localparam logic signed [11:0] KB_U_709 = 12'(int'(1.8556 * SCALE));

    localparam logic signed [DIFF_W-1:0] OFF  = DIFF_W'(1 << (DATA_W - 1));
    localparam logic signed [SUM_W-1:0]  HALF = SUM_W'(1 << (FRAC - 1));
    localparam logic signed [SUM_W-1:0]  MAXV = SUM_W'((1 << DATA_W) - 1);

    // Returns {clipped, clamped value} for one rounded sum.
    function automatic logic [DATA_W:0] clamp_px(input logic signed [SUM_W-1:0] sum);
        logic signed [SUM_W-1:0] res;
        res = sum >>> FRAC;
        if (res[SUM_W-1])
            clamp_px = {1'b1, {DATA_W{1'b0}}};
        else if (res > MAXV)
            clamp_px = {1'b1, {DATA_W{1'b1}}};
        else
            clamp_px = {1'b0, res[DATA_W-1:0]};
    endfunction

    logic w_en;

    logic                     r_s1_valid, r_s1_mode, r_s1_sof, r_s1_eol;
    logic [DATA_W-1:0]        r_s1_y;
    logic signed [DIFF_W-1:0] r_s1_ud, r_s1_vd;

    logic                     r_s2_valid, r_s2_sof, r_s2_eol;
    logic [DATA_W-1:0]        r_s2_y;
    logic signed [PROD_W-1:0] r_s2_rv, r_s2_gu, r_s2_gv, r_s2_bu;

    logic                     r_out_valid, r_out_sof, r_out_eol;
    logic [DATA_W-1:0]        r_out_r, r_out_g, r_out_b;
    logic [SATC_W-1:0]        r_sat_cnt;

    logic signed [11:0]       w_kr_v, w_kg_u, w_kg_v, w_kb_u;
    logic signed [SUM_W-1:0]  w_base, w_sum_r, w_sum_g, w_sum_b;
    logic [DATA_W:0]          w_cr, w_cg, w_cb;
    logic [1:0]               w_clips;
    logic [SATC_W:0]          w_sat_next;

    // The whole pipeline advances together whenever the output slot is free.
    assign w_en     = !r_out_valid || out_ready;
    assign in_ready = w_en;

    // Coefficient set follows the mode carried with the pixel in stage 1.
    always_comb begin
        // NOTE: every always_comb output gets a value on every path, so no latch is inferred.
        w_kr_v = KR_V_601;
        w_kg_u = KG_U_601;
        w_kg_v = KG_V_601;
        w_kb_u = KB_U_601;
        if (r_s1_mode) begin
            w_kr_v = KR_V_709;
            w_kg_u = KG_U_709;
            w_kg_v = KG_V_709;
            w_kb_u = KB_U_709;
        end
    end

    // Stage-3 sums, rounding, clamping and clip count.
    always_comb begin
        w_base  = $signed({{(SUM_W - DATA_W - FRAC){1'b0}}, r_s2_y, {FRAC{1'b0}}});
        w_sum_r = w_base + SUM_W'(r_s2_rv) + HALF;
        w_sum_g = w_base + SUM_W'(r_s2_gu) + SUM_W'(r_s2_gv) + HALF;
        w_sum_b = w_base + SUM_W'(r_s2_bu) + HALF;
        w_cr    = clamp_px(w_sum_r);
        w_cg    = clamp_px(w_sum_g);
        w_cb    = clamp_px(w_sum_b);
        w_clips = {1'b0, w_cr[DATA_W]} + {1'b0, w_cg[DATA_W]} + {1'b0, w_cb[DATA_W]};
        w_sat_next = {1'b0, r_sat_cnt} + {{(SATC_W - 1){1'b0}}, w_clips};
    end

    // Stage 1: register the pixel, offset-removed chroma and sideband.
    always_ff @(posedge clk or posedge rst) begin
        // NOTE: data registers are reset too; they are few and it keeps X out of the datapath.
        if (rst) begin
            // NOTE: sequential state uses non-blocking assignments so all registers update together.
            r_s1_valid <= 1'b0;
            r_s1_mode  <= 1'b0;
            r_s1_sof   <= 1'b0;
            r_s1_eol   <= 1'b0;
            r_s1_y     <= '0;
            r_s1_ud    <= '0;
            r_s1_vd    <= '0;
        end else if (w_en) begin
            r_s1_valid <= in_valid;
            r_s1_mode  <= in_mode;
            r_s1_sof   <= in_sof;
            r_s1_eol   <= in_eol;
            r_s1_y     <= in_y;
            r_s1_ud    <= $signed({1'b0, in_u}) - OFF;
            r_s1_vd    <= $signed({1'b0, in_v}) - OFF;
        end
    end

    // Stage 2: register the four chroma products.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_s2_valid <= 1'b0;
            r_s2_sof   <= 1'b0;
            r_s2_eol   <= 1'b0;
            r_s2_y     <= '0;
            r_s2_rv    <= '0;
            r_s2_gu    <= '0;
            r_s2_gv    <= '0;
            r_s2_bu    <= '0;
        end else if (w_en) begin
            r_s2_valid <= r_s1_valid;
            r_s2_sof   <= r_s1_sof;
            r_s2_eol   <= r_s1_eol;
            r_s2_y     <= r_s1_y;
            r_s2_rv    <= PROD_W'(w_kr_v) * PROD_W'(r_s1_vd);
            r_s2_gu    <= PROD_W'(w_kg_u) * PROD_W'(r_s1_ud);
            r_s2_gv    <= PROD_W'(w_kg_v) * PROD_W'(r_s1_vd);
            r_s2_bu    <= PROD_W'(w_kb_u) * PROD_W'(r_s1_ud);
        end
    end

    // Stage 3: register the clamped RGB result and sideband.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_out_valid <= 1'b0;
            r_out_sof   <= 1'b0;
            r_out_eol   <= 1'b0;
            r_out_r     <= '0;
            r_out_g     <= '0;
            r_out_b     <= '0;
        end else if (w_en) begin
            r_out_valid <= r_s2_valid;
            r_out_sof   <= r_s2_sof;
            r_out_eol   <= r_s2_eol;
            r_out_r     <= w_cr[DATA_W-1:0];
            r_out_g     <= w_cg[DATA_W-1:0];
            r_out_b     <= w_cb[DATA_W-1:0];
        end
    end

    // Saturating clip counter; clear wins over a same-cycle increment.
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            r_sat_cnt <= '0;
        else if (sat_clr)
            r_sat_cnt <= '0;
        else if (w_en && r_s2_valid)
            r_sat_cnt <= w_sat_next[SATC_W] ? {SATC_W{1'b1}} : w_sat_next[SATC_W-1:0];
    end

    assign out_valid = r_out_valid;
    assign out_sof   = r_out_sof;
    assign out_eol   = r_out_eol;
    assign out_r     = r_out_r;
    assign out_g     = r_out_g;
    assign out_b     = r_out_b;
    assign sat_cnt   = r_sat_cnt;

endmodule

// File: tb/tb_yuv2rgb_pipe.sv
// tb_yuv2rgb_pipe: directed and randomized checks of yuv2rgb_pipe
// (DATA_W=8, FRAC=8) against a plain-arithmetic reference model.
module tb_yuv2rgb_pipe;

    logic       clk = 1'b0;
    logic       rst;
    logic       in_valid, in_ready, in_mode, in_sof, in_eol;
    logic [7:0] in_y, in_u, in_v;
    logic       out_valid, out_ready, out_sof, out_eol;
    logic [7:0] out_r, out_g, out_b;
    logic [15:0] sat_cnt;
    logic       sat_clr;

    int n_checks = 0;
    int n_pass   = 0;

    logic [25:0] exp_q[$];
    int          sat_model = 0;

    yuv2rgb_pipe dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_y(in_y), .in_u(in_u), .in_v(in_v),
        .in_mode(in_mode), .in_sof(in_sof), .in_eol(in_eol),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_r(out_r), .out_g(out_g), .out_b(out_b),
        .out_sof(out_sof), .out_eol(out_eol),
        .sat_cnt(sat_cnt), .sat_clr(sat_clr)
    );

    always #5 clk = ~clk;

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    endtask

    // Reference conversion straight from the matrix equations, integer maths.
    function automatic void ref_px(input int y, input int u, input int v, input bit mode,
                                   output logic [23:0] rgb, output int clips);
        int kr, kgu, kgv, kbu, ud, vd;
        int s[3];
        kr  = mode ? 403 : 359;
        kgu = mode ? -48 : -88;
        kgv = mode ? -120 : -183;
        kbu = mode ? 475 : 454;
        ud = u - 128;
        vd = v - 128;
        s[0] = (y * 256 + kr * vd + 128) >>> 8;
        s[1] = (y * 256 + kgu * ud + kgv * vd + 128) >>> 8;
        s[2] = (y * 256 + kbu * ud + 128) >>> 8;
        clips = 0;
        for (int i = 0; i < 3; i++) begin
            if (s[i] < 0) begin s[i] = 0; clips++; end
            else if (s[i] > 255) begin s[i] = 255; clips++; end
        end
        rgb = {s[0][7:0], s[1][7:0], s[2][7:0]};
    endfunction

    function automatic int sat_add(input int a, input int b);
        return (a + b > 65535) ? 65535 : a + b;
    endfunction

    // One clock: record handshakes seen just before the next rising edge.
    task automatic cycle(output bit acc);
        logic [23:0] rgb;
        int c;
        #1;
        acc = in_valid && in_ready;
        if (acc) begin
            ref_px(in_y, in_u, in_v, in_mode, rgb, c);
            exp_q.push_back({rgb, in_sof, in_eol});
            sat_model = sat_add(sat_model, c);
        end
        if (out_valid && out_ready) begin
            if (exp_q.size() == 0) check("unexpected_beat", 1, 0);
            else check("beat", {out_r, out_g, out_b, out_sof, out_eol}, exp_q.pop_front());
        end
        @(negedge clk);
    endtask

    task automatic drain(input string tag);
        bit acc;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        for (int i = 0; i < 20 && exp_q.size() > 0; i++) cycle(acc);
        check({tag, "_drained"}, exp_q.size(), 0);
    endtask

    // Single beat, fixed latency and result checked from spec constants.
    task automatic directed(input string tag, input int y, input int u, input int v,
                            input bit mode, input logic [23:0] exp_rgb, input int exp_sat);
        in_y = 8'(y); in_u = 8'(u); in_v = 8'(v); in_mode = mode;
        in_sof = 1'b0; in_eol = 1'b0;
        in_valid = 1'b1; out_ready = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        @(negedge clk);
        check({tag, "_early"}, out_valid, 0);
        @(negedge clk);
        check({tag, "_valid"}, out_valid, 1);
        check({tag, "_rgb"}, {out_r, out_g, out_b}, exp_rgb);
        check({tag, "_sat"}, sat_cnt, exp_sat);
        @(negedge clk);
    endtask

    initial begin
        bit acc;
        int idx, phase, hold;
        logic [25:0] captured;

        rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1; sat_clr = 1'b0;
        in_y = '0; in_u = '0; in_v = '0; in_mode = 1'b0; in_sof = 1'b0; in_eol = 1'b0;
        repeat (2) @(negedge clk);
        check("rst_out_valid", out_valid, 0);
        check("rst_in_ready", in_ready, 1);
        check("rst_rgb", {out_r, out_g, out_b, out_sof, out_eol}, 0);
        check("rst_sat", sat_cnt, 0);
        rst = 1'b0;
        @(negedge clk);

        directed("grey601", 128, 128, 128, 1'b0, 24'h808080, 0);
        directed("grey709", 128, 128, 128, 1'b1, 24'h808080, 0);
        directed("red_clip", 255, 128, 255, 1'b0, {8'd255, 8'd164, 8'd255}, 1);
        directed("black", 0, 0, 0, 1'b0, {8'd0, 8'd136, 8'd0}, 3);
        sat_model = 3;

        // Clear coincident with a clipping beat reaching the output.
        in_y = 0; in_u = 0; in_v = 0; in_mode = 1'b0; in_valid = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        @(negedge clk);
        sat_clr = 1'b1;
        @(negedge clk);
        sat_clr = 1'b0;
        check("clr_coincident_valid", out_valid, 1);
        check("clr_coincident_sat", sat_cnt, 0);
        @(negedge clk);
        check("clr_after", sat_cnt, 0);
        sat_model = 0;

        // Randomized traffic with random bubbles and back-pressure.
        for (int i = 0; i < 1500; i++) begin
            in_valid  = ($urandom_range(0, 3) != 0);
            out_ready = ($urandom_range(0, 3) != 0);
            in_y = ($urandom_range(0, 7) == 0) ? 8'd0 : 8'($urandom);
            in_u = ($urandom_range(0, 7) == 0) ? 8'd255 : 8'($urandom);
            in_v = 8'($urandom);
            in_mode = 1'($urandom);
            in_sof  = 1'($urandom);
            in_eol  = 1'($urandom);
            cycle(acc);
        end
        drain("random");
        check("random_sat", sat_cnt, sat_model);

        // Five-beat burst, output stalled from the first valid output.
        idx = 0; phase = 0; hold = 0; captured = '0;
        for (int i = 0; i < 60 && !(idx == 5 && phase == 2 && exp_q.size() == 0); i++) begin
            in_valid = (idx < 5);
            in_y = 8'(40 * idx + 10); in_u = 8'(200 - 30 * idx); in_v = 8'(60 + 35 * idx);
            in_mode = idx[0];
            in_sof = (idx == 0);
            in_eol = (idx == 4);
            if (phase == 0 && out_valid) begin
                phase = 1;
                captured = {out_r, out_g, out_b, out_sof, out_eol};
            end
            if (phase == 1) begin
                out_ready = 1'b0;
                #1;
                check("stall_in_ready", in_ready, 0);
                check("stall_valid", out_valid, 1);
                check("stall_hold", {out_r, out_g, out_b, out_sof, out_eol}, captured);
                hold++;
                if (hold == 4) phase = 2;
            end else begin
                out_ready = 1'b1;
            end
            cycle(acc);
            if (acc) idx++;
        end
        check("stall_all_sent", idx, 5);
        check("stall_all_out", exp_q.size(), 0);
        drain("stall");

        // Reset with two beats in flight.
        for (int i = 0; i < 2; i++) begin
            in_valid = 1'b1; in_y = 8'(100 + i); in_u = 8'd30; in_v = 8'd220; in_mode = 1'b0;
            cycle(acc);
        end
        in_valid = 1'b0;
        rst = 1'b1;
        #1;
        check("inflight_rst_valid", out_valid, 0);
        check("inflight_rst_sat", sat_cnt, 0);
        check("inflight_rst_ready", in_ready, 1);
        exp_q.delete();
        sat_model = 0;
        @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < 8; i++) cycle(acc);
        check("no_stale_valid", out_valid, 0);
        directed("post_rst", 128, 128, 128, 1'b0, 24'h808080, 0);

        // Saturation: more than 2^16 clipped components.
        sat_clr = 1'b1;
        @(negedge clk);
        sat_clr = 1'b0;
        sat_model = 0;
        in_y = 0; in_u = 0; in_v = 0; in_mode = 1'b0;
        in_valid = 1'b1; out_ready = 1'b1;
        for (int i = 0; i < 32800; i++) begin
            ref_px(0, 0, 0, 1'b0, captured[25:2], hold);
            sat_model = sat_add(sat_model, hold);
            @(negedge clk);
        end
        in_valid = 1'b0;
        repeat (5) @(negedge clk);
        check("sat_hold", sat_cnt, sat_model);
        check("sat_allones", sat_cnt, 16'hFFFF);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
